// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the difficulty-scaled game timer.
package game_timer_pkg;

    localparam int unsigned CLKS_PER_MS_DEFAULT = 50000;
    localparam int unsigned WIDTH_DEFAULT       = 12;
    localparam int unsigned STEP_W              = 3;

    typedef enum logic [1:0] {
        DIFF_EASY    = 2'd0,
        DIFF_MEDIUM  = 2'd1,
        DIFF_HARD    = 2'd2,
        DIFF_EXTREME = 2'd3
    } difficulty_t;

    // Game-ms advanced per real ms: 1..4.
    function automatic logic [STEP_W-1:0] diff_step(input difficulty_t diff);
        return STEP_W'(diff) + STEP_W'(1);
    endfunction

endpackage

// File: rtl/game_timer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle ms_tick every CLKS_PER_MS cycles of run; holds while run is low.
module ms_tick_gen
    import game_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic ms_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by run so a freeze on the wrap count cannot emit a tick.
    assign ms_tick = run && wrap;

endmodule

// File: rtl/game_timer.sv
// Difficulty-scaled ms up-counter clamped at end_value.
// Optional end_pulse output when TIMER_END_PULSE_EN is defined.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
    parameter int unsigned WIDTH       = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       difficulty,
    input  logic [WIDTH-1:0] end_value,
    output logic [WIDTH-1:0] timer_value,
    output logic             end_reached
`ifdef TIMER_END_PULSE_EN
    ,
    output logic             end_pulse
`endif
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0]  timer_q;
    logic [WIDTH-1:0]  timer_d;
    logic [STEP_W-1:0] step;
    logic [SUM_W-1:0]  sum;
    logic              ms_tick;
    logic              run;

    assign end_reached = (timer_q >= end_value);
    assign run         = enable && !end_reached;

    ms_tick_gen #(
        .CLKS_PER_MS(CLKS_PER_MS)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .ms_tick(ms_tick)
    );

    // Sum is one bit wider so the clamp sees a carry instead of a wrapped value.
    always_comb begin
        step    = diff_step(difficulty_t'(difficulty));
        sum     = {1'b0, timer_q} + SUM_W'(step);
        timer_d = timer_q;
        if (ms_tick) begin
            timer_d = (sum > {1'b0, end_value}) ? end_value : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_value = timer_q;

`ifdef TIMER_END_PULSE_EN
    logic end_reached_q;
    logic end_pulse_q;

    // Rising-edge detect of end_reached, one cycle late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            end_reached_q <= 1'b0;
            end_pulse_q   <= 1'b0;
        end else begin
            end_reached_q <= end_reached;
            end_pulse_q   <= end_reached && !end_reached_q;
        end
    end

    assign end_pulse = end_pulse_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer with a short prescaler (10 clk per ms).
// Define TIMER_END_PULSE_EN to also check end_pulse.
module tb_game_timer;

    localparam int unsigned N     = 10;
    localparam int unsigned WIDTH = 12;

    localparam int K_VAL   = 0;
    localparam int K_RST   = 1;
    localparam int K_PULSE = 2;

    typedef struct {
        int               kind;
        int               cyc;
        logic [WIDTH-1:0] val;
        logic             endr;
        int               pulse;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [1:0]       difficulty;
    logic [WIDTH-1:0] end_value;
    logic [WIDTH-1:0] timer_value;
    logic             end_reached;
`ifdef TIMER_END_PULSE_EN
    logic             end_pulse;
    int               pulse_cnt  = 0;
    int               pulse_base = 0;
`endif

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur;
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;
    bit    abort    = 1'b0;

    game_timer #(
        .CLKS_PER_MS(N),
        .WIDTH      (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .difficulty (difficulty),
        .end_value  (end_value),
        .timer_value(timer_value),
        .end_reached(end_reached)
`ifdef TIMER_END_PULSE_EN
        ,
        .end_pulse  (end_pulse)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Posedges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void push(input string nm, input int c, input int v, input bit e, input int p);
        exp_t x;
        x.kind  = K_VAL;
        x.cyc   = c;
        x.val   = WIDTH'(v);
        x.endr  = e;
        x.pulse = p;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endfunction

    function automatic void push_kind(input string nm, input int k, input int p);
        exp_t x;
        x.kind  = k;
        x.cyc   = 0;
        x.val   = '0;
        x.endr  = 1'b0;
        x.pulse = p;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endfunction

    // Monitor: pops expectations as their sample point arrives.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q[0];
            if (abort) begin
                checks++;
                failures++;
                $display("FAIL %s timeout: %0d expectations unmatched, required 0", name_q[0], exp_q.size());
                exp_q.delete();
                name_q.delete();
            end else if (cur.kind == K_PULSE) begin
`ifdef TIMER_END_PULSE_EN
                checks++;
                if (pulse_cnt - pulse_base != cur.pulse) begin
                    failures++;
                    $display("FAIL %s: end_pulse count=%0d, required %0d", name_q[0], pulse_cnt - pulse_base, cur.pulse);
                end
`endif
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end else if ((cur.kind == K_RST && !reset) || (cur.kind == K_VAL && cyc == cur.cyc)) begin
                checks++;
                if (timer_value !== cur.val || end_reached !== cur.endr) begin
                    failures++;
                    $display("FAIL %s: timer_value=%0d end_reached=%b, required %0d/%b",
                             name_q[0], timer_value, end_reached, cur.val, cur.endr);
                end
`ifdef TIMER_END_PULSE_EN
                if (cur.pulse >= 0) begin
                    checks++;
                    if (end_pulse !== cur.pulse[0]) begin
                        failures++;
                        $display("FAIL %s_pulse: end_pulse=%b, required %0d", name_q[0], end_pulse, cur.pulse);
                    end
                end
`endif
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end else if (cur.kind == K_VAL && cyc > cur.cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed: cycle=%0d, required sample at %0d", name_q[0], cyc, cur.cyc);
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
`ifdef TIMER_END_PULSE_EN
        if (end_pulse === 1'b1) pulse_cnt++;
`endif
    end

    task automatic start(input logic [1:0] d, input int ev);
        @(posedge clk);
        #2 reset = 1'b0;
        enable     = 1'b1;
        difficulty = d;
        end_value  = WIDTH'(ev);
        repeat (3) @(posedge clk);
        #5 reset = 1'b1;
`ifdef TIMER_END_PULSE_EN
        pulse_base = pulse_cnt;
`endif
    endtask

    task automatic wait_empty(input string nm);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            abort = 1'b1;
            b = 0;
            while (exp_q.size() != 0 && b < 5) begin
                @(negedge clk);
                b++;
            end
            abort = 1'b0;
            if (exp_q.size() != 0) begin
                $display("FAIL %s: scoreboard stuck, required empty queue", nm);
                $fatal(1, "scoreboard stuck");
            end
        end
    endtask

    task automatic drain(input string nm, input int exp_pulses);
        wait_empty(nm);
`ifdef TIMER_END_PULSE_EN
        push_kind({nm, "_pulses"}, K_PULSE, exp_pulses);
        wait_empty(nm);
`else
        if (exp_pulses < 0) $display("note: negative pulse expectation for %s", nm);
`endif
    endtask

    task automatic wait_cyc(input int n);
        int b;
        b = 0;
        while (cyc != n && b < 5000) begin
            @(negedge clk);
            b++;
        end
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        difficulty = 2'd0;
        end_value  = WIDTH'(100);

        // Easy: one game-ms per ms, stops at 100.
        start(2'd0, 100);
        push("t1_release", 0,    0,   1'b0, 0);
        push("t1_49ms",    499,  49,  1'b0, -1);
        push("t1_50ms",    500,  50,  1'b0, -1);
        push("t1_99ms",    999,  99,  1'b0, -1);
        push("t1_100ms",   1000, 100, 1'b1, 0);
        push("t1_pulse",   1001, 100, 1'b1, 1);
        push("t1_after",   1002, 100, 1'b1, 0);
        push("t1_110ms",   1100, 100, 1'b1, -1);
        drain("t1", 1);

        // Medium: two per ms; first tick exactly one ms after release.
        start(2'd1, 100);
        push("t2_pretick", 9,   0,   1'b0, -1);
        push("t2_1ms",     10,  2,   1'b0, -1);
        push("t2_49ms",    499, 98,  1'b0, -1);
        push("t2_50ms",    500, 100, 1'b1, -1);
        push("t2_51ms",    510, 100, 1'b1, -1);
        drain("t2", 1);

        // Hard: 99 then clamp to 100 rather than 102.
        start(2'd2, 100);
        push("t3_33ms",   330, 99,  1'b0, -1);
        push("t3_pre34",  339, 99,  1'b0, -1);
        push("t3_clamp",  340, 100, 1'b1, -1);
        push("t3_hold",   360, 100, 1'b1, -1);
        drain("t3", 1);

        // Enable low 20..30 ms freezes without losing a tick.
        start(2'd0, 100);
        push("t4_20ms",   200,  20,  1'b0, -1);
        push("t4_frozen", 250,  20,  1'b0, -1);
        push("t4_30ms",   300,  20,  1'b0, -1);
        push("t4_pre",    309,  20,  1'b0, -1);
        push("t4_resume", 310,  21,  1'b0, -1);
        push("t4_109ms",  1099, 99,  1'b0, -1);
        push("t4_110ms",  1100, 100, 1'b1, -1);
        wait_cyc(200);
        enable = 1'b0;
        wait_cyc(300);
        enable = 1'b1;
        drain("t4", 1);

        // Async reset mid-count.
        start(2'd3, 100);
        push("t4b_12ms", 125, 48, 1'b0, -1);
        wait_empty("t4b");
        push_kind("t4b_async", K_RST, -1);
        cur.val = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        wait_empty("t4b_async");

        // end_value 0: ended from reset release.
        start(2'd0, 0);
        push("t5a_release", 0,   0, 1'b1, 0);
        push("t5a_pulse",   1,   0, 1'b1, 1);
        push("t5a_after",   2,   0, 1'b1, 0);
        push("t5a_10ms",    100, 0, 1'b1, -1);
        drain("t5a", 1);

        // end_value cut below count, then raised: holds, then resumes from held prescaler.
        start(2'd0, 100);
        push("t5b_50ms",   500, 50, 1'b0, -1);
        push("t5b_precut", 505, 50, 1'b0, -1);
        push("t5b_cut",    506, 50, 1'b1, -1);
        push("t5b_pulse",  507, 50, 1'b1, 1);
        push("t5b_after",  508, 50, 1'b1, 0);
        push("t5b_held",   700, 50, 1'b1, -1);
        push("t5b_raise",  701, 50, 1'b0, -1);
        push("t5b_pre",    704, 50, 1'b0, -1);
        push("t5b_resume", 705, 51, 1'b0, -1);
        wait_cyc(505);
        @(posedge clk);
        #2 end_value = WIDTH'(40);
        wait_cyc(700);
        @(posedge clk);
        #2 end_value = WIDTH'(100);
        drain("t5b", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
